// File: rtl/grf_regfile_if.sv
// ---------------------------------------------------------------------------
// grf_regfile_if -- register-file access bus.
//   WE3  write enable (active-high)
//   PC   address of the writing instruction (write log only)
//   A1   read address, port 1      RD1  read data, port 1
//   A2   read address, port 2      RD2  read data, port 2
//   A3   write address             WD   write data
// master: the CPU side that drives addresses/data and receives read data.
// slave : the register file.
// ---------------------------------------------------------------------------
interface grf_regfile_if;
  logic        WE3;
  logic [31:0] PC;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [31:0] RD1;
  logic [31:0] RD2;

  modport master (
    output WE3, PC, A1, A2, A3, WD,
    input  RD1, RD2
  );

  modport slave (
    input  WE3, PC, A1, A2, A3, WD,
    output RD1, RD2
  );
endinterface

// File: rtl/grf_regfile.sv
// ---------------------------------------------------------------------------
// grf_regfile -- 32 x 32-bit register file, two combinational read ports and
// one synchronous write port. Register 0 is hard-wired to zero.
//   clk    sole clock, rising edge
//   reset  asynchronous, active-low; clears all registers immediately
//   bus    grf_regfile_if.slave (WE3, PC, A1, A2, A3, WD in; RD1, RD2 out)
// Parameter BYPASS: 1 forwards a same-cycle write onto the read ports before
// the edge; 0 shows stored contents only.
// Each committed write prints "@PC: $A3 <= WD" in simulation.
// ---------------------------------------------------------------------------
module grf_regfile #(
  parameter int BYPASS = 0
) (
  input  logic          clk,
  input  logic          reset,
  grf_regfile_if.slave  bus
);

  logic [31:0] r_regs [32];
  logic        w_wr_en;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  // A write commits only for a known-1 enable outside reset and a non-zero
  // target; an X/Z enable compares as not-equal and so never writes.
  assign w_wr_en = (bus.WE3 == 1'b1) && (bus.A3 != 5'd0) && (reset == 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0000_0000;
      end
    end else if (w_wr_en) begin
      r_regs[bus.A3] <= bus.WD;
`ifndef SYNTHESIS
      $display("@%h: $%d <= %h", bus.PC, bus.A3, bus.WD);
`endif
    end
  end

  // Register 0 is never written and is cleared by reset, so it reads zero
  // without a dedicated mux.
  always_comb begin
    w_rd1 = r_regs[bus.A1];
    w_rd2 = r_regs[bus.A2];
    if (BYPASS != 0) begin
      if (w_wr_en && (bus.A1 == bus.A3)) w_rd1 = bus.WD;
      if (w_wr_en && (bus.A2 == bus.A3)) w_rd2 = bus.WD;
    end
  end

  assign bus.RD1 = w_rd1;
  assign bus.RD2 = w_rd2;

endmodule

// File: tb/tb_grf_regfile.sv
// ---------------------------------------------------------------------------
// tb_grf_regfile -- directed bench driving a BYPASS=0 and a BYPASS=1 register
// file with identical stimulus and checking reads against hand-computed values.
// ---------------------------------------------------------------------------
module tb_grf_regfile;

  logic clk;
  logic reset;
  int   nchecks;
  int   nerr;

  grf_regfile_if if0 ();
  grf_regfile_if if1 ();

  grf_regfile #(.BYPASS(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  grf_regfile #(.BYPASS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [31:0] pc,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd);
    if0.WE3 = we; if0.PC = pc; if0.A1 = a1; if0.A2 = a2; if0.A3 = a3; if0.WD = wd;
    if1.WE3 = we; if1.PC = pc; if1.A1 = a1; if1.A2 = a2; if1.A3 = a3; if1.WD = wd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nchecks = 0;
    nerr    = 0;

    // Reset held for two cycles.
    reset = 1'b0;
    drive(1'b0, 32'h0, 5'd5, 5'd31, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd1_b0", if0.RD1, 32'h0);
    check("rst_rd2_b0", if0.RD2, 32'h0);
    check("rst_rd1_b1", if1.RD1, 32'h0);
    check("rst_rd2_b1", if1.RD2, 32'h0);

    // Release reset; write to register 0 is discarded.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h0000_00F0, 5'd0, 5'd0, 5'd0, 32'd10);
    @(posedge clk); #1;
    check("r0_wr_b0", if0.RD1, 32'h0);
    check("r0_wr_b1", if1.RD1, 32'h0);

    // Two successive writes.
    @(negedge clk);
    drive(1'b1, 32'h0000_0100, 5'd0, 5'd0, 5'd1, 32'd99);
    @(negedge clk);
    drive(1'b1, 32'h0000_0104, 5'd0, 5'd0, 5'd2, 32'd2);
    @(negedge clk);
    drive(1'b0, 32'h0000_0108, 5'd1, 5'd2, 5'd0, 32'h0);
    #1;
    check("wr_r1_b0", if0.RD1, 32'h0000_0063);
    check("wr_r2_b0", if0.RD2, 32'h0000_0002);
    check("wr_r1_b1", if1.RD1, 32'h0000_0063);
    check("wr_r2_b1", if1.RD2, 32'h0000_0002);

    // Same-cycle read of the address being written, port 1.
    @(negedge clk);
    drive(1'b1, 32'h0000_010C, 5'd3, 5'd1, 5'd3, 32'd3);
    #1;
    check("byp1_pre_b0", if0.RD1, 32'h0);
    check("byp1_pre_b1", if1.RD1, 32'h3);
    check("byp1_other_b1", if1.RD2, 32'h0000_0063);
    @(posedge clk); #1;
    check("byp1_post_b0", if0.RD1, 32'h3);
    check("byp1_post_b1", if1.RD1, 32'h3);

    // Same-cycle read of the address being written, port 2.
    @(negedge clk);
    drive(1'b1, 32'h0000_0110, 5'd3, 5'd4, 5'd4, 32'h0000_0044);
    #1;
    check("byp2_pre_b0", if0.RD2, 32'h0);
    check("byp2_pre_b1", if1.RD2, 32'h0000_0044);
    check("byp2_rd1_b1", if1.RD1, 32'h3);
    @(posedge clk); #1;
    check("byp2_post_b0", if0.RD2, 32'h0000_0044);

    // Write disabled over several edges.
    @(negedge clk);
    drive(1'b0, 32'h0000_0114, 5'd1, 5'd4, 5'd1, 32'hFFFF_FFFF);
    #1;
    check("we0_pre_b1", if1.RD1, 32'h0000_0063);
    repeat (3) @(posedge clk);
    #1;
    check("we0_r1_b0", if0.RD1, 32'h0000_0063);
    check("we0_r1_b1", if1.RD1, 32'h0000_0063);
    check("we0_r4_b0", if0.RD2, 32'h0000_0044);

    // Unknown write enable is no write.
    @(negedge clk);
    drive(1'bx, 32'h0000_0118, 5'd1, 5'd2, 5'd1, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("wex_r1_b0", if0.RD1, 32'h0000_0063);
    check("wex_r1_b1", if1.RD1, 32'h0000_0063);

    // Mid-cycle asynchronous reset.
    @(negedge clk);
    drive(1'b0, 32'h0000_011C, 5'd1, 5'd2, 5'd0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_rd1_b0", if0.RD1, 32'h0);
    check("arst_rd2_b0", if0.RD2, 32'h0);
    check("arst_rd1_b1", if1.RD1, 32'h0);
    check("arst_rd2_b1", if1.RD2, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int a = 1; a < 32; a++) begin
      if0.A1 = 5'(a); if0.A2 = 5'(a);
      if1.A1 = 5'(a); if1.A2 = 5'(a);
      #1;
      check($sformatf("clr_r%0d_b0", a), if0.RD1, 32'h0);
      check($sformatf("clr_r%0d_b1", a), if1.RD2, 32'h0);
    end

    // First write after reset release lands on the next edge.
    @(negedge clk);
    drive(1'b1, 32'h0000_0120, 5'd5, 5'd0, 5'd5, 32'h0000_0055);
    #1;
    check("post_rst_pre_b0", if0.RD1, 32'h0);
    @(posedge clk); #1;
    check("post_rst_wr_b0", if0.RD1, 32'h0000_0055);
    check("post_rst_wr_b1", if1.RD1, 32'h0000_0055);
    @(negedge clk);
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
